// File: rtl/mux2x1_rr_sel_ctrl_pkg.sv
// Shared types for the two-channel round-robin mux select controller.
// State encodings and the default data width live here.
package mux2x1_rr_sel_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

endpackage

// File: rtl/mux2x1_rr_sel_ctrl_if.sv
// Bus bundle for the round-robin mux controller: two input streams,
// the registered mux select and the output stream.
interface mux2x1_rr_sel_ctrl_if
  import mux2x1_rr_sel_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             a0_valid;
  logic [WIDTH-1:0] a0_data;
  logic             a0_ready;
  logic             a1_valid;
  logic [WIDTH-1:0] a1_data;
  logic             a1_ready;
  logic             s;
  logic             y_valid;
  logic [WIDTH-1:0] y;
  logic             y_ready;

  modport master (
    output a0_valid, a0_data,
    input  a0_ready,
    output a1_valid, a1_data,
    input  a1_ready,
    input  s, y_valid, y,
    output y_ready
  );

  modport slave (
    input  a0_valid, a0_data,
    output a0_ready,
    input  a1_valid, a1_data,
    output a1_ready,
    output s, y_valid, y,
    input  y_ready
  );

endinterface

// File: rtl/mux2xN_dataflow.sv
// WIDTH-bit 2:1 dataflow mux; s=0 selects a0, s=1 selects a1.
module mux2xN_dataflow #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] y,
  input  logic             s,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mux2x1_rr_sel_ctrl.sv
// Round-robin grant FSM with burst cap driving the mux select, plus a
// one-entry output register fed through the 2:1 data mux.
module mux2x1_rr_sel_ctrl
  import mux2x1_rr_sel_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux2x1_rr_sel_ctrl_if.slave  bus
);

  localparam int CW = $clog2(MAX_BURST + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_BEAT = cnt_t'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic             s_q, s_d;
  logic             last_q, last_d;
  cnt_t             burst_q, burst_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             yv_q, yv_d;
  logic [WIDTH-1:0] mux_y;
  logic             space;
  logic             gx;
  logic             ax_v;
  logic             ox_v;

  mux2xN_dataflow #(
    .WIDTH(WIDTH)
  ) u_mux (
    .y  (mux_y),
    .s  (s_q),
    .a0 (bus.a0_data),
    .a1 (bus.a1_data)
  );

  assign space = ~yv_q | bus.y_ready;
  assign gx    = (state_q == ST_GNT1);
  assign ax_v  = gx ? bus.a1_valid : bus.a0_valid;
  assign ox_v  = gx ? bus.a0_valid : bus.a1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    last_d       = last_q;
    burst_d      = burst_q;
    y_d          = y_q;
    yv_d         = yv_q;
    bus.a0_ready = 1'b0;
    bus.a1_ready = 1'b0;
    if (bus.y_ready) yv_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Tie goes to the channel that was not served last
        unique case (1'b1)
          bus.a0_valid & (~bus.a1_valid | last_q): begin
            state_d = ST_GNT0;
            s_d     = 1'b0;
          end
          bus.a1_valid & (~bus.a0_valid | ~last_q): begin
            state_d = ST_GNT1;
            s_d     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_GNT0, ST_GNT1: begin
        bus.a0_ready = ~gx & space;
        bus.a1_ready = gx & space;
        if (ax_v & space) begin
          y_d  = mux_y;
          yv_d = 1'b1;
          if (burst_q == LAST_BEAT) begin
            burst_d = '0;
            if (ox_v) begin
              state_d = gx ? ST_GNT0 : ST_GNT1;
              s_d     = ~gx;
              last_d  = gx;
            end
          end else begin
            burst_d = burst_q + cnt_t'(1);
          end
        end else if (space) begin
          state_d = ST_IDLE;
          last_d  = gx;
          burst_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.s       = s_q;
  assign bus.y       = y_q;
  assign bus.y_valid = yv_q;

endmodule
